// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S sample receiver.
// Channel encoding follows the word_select line: low selects left, high selects right.
package i2s_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Bits needed to hold a bit count from 0 up to and including num_bits.
    function automatic int count_width(input int num_bits);
        return $clog2(num_bits + 1);
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Show-ahead stereo frame FIFO.
// A push that arrives while full is dropped and flagged on overrun, unless a pop frees a slot in the same cycle.
module i2s_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic full_s;
    logic empty_s;
    logic pop_s;
    logic wr_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign pop_s     = !empty_s && pop_ready;
    assign wr_s      = push && (!full_s || pop_s);
    assign overrun   = push && full_s && !pop_s;
    assign valid     = !empty_s;
    assign head_data = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/i2s_sample_rx.sv
// I2S-style receiver: oversamples s_clk/word_select/serial_data in the clk domain,
// deserialises left/right words and queues complete stereo frames behind a valid/ready handshake.
module i2s_sample_rx
    import i2s_pkg::*;
#(
    parameter int NUM_BITS_DAC = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_clk,
    input  logic                    word_select,
    input  logic                    serial_data,
    output logic [NUM_BITS_DAC-1:0] sample_left,
    output logic [NUM_BITS_DAC-1:0] sample_right,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    output logic                    short_word
);

    localparam int                CNT_W    = count_width(NUM_BITS_DAC);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_BITS_DAC);
    localparam int                FRAME_W  = 2 * NUM_BITS_DAC;

    logic [SYNC_STAGES-1:0]  sclk_sync_r;
    logic [SYNC_STAGES-1:0]  ws_sync_r;
    logic [SYNC_STAGES-1:0]  sd_sync_r;
    logic                    sclk_d_r;

    logic                    rise_s;
    logic                    ws_s;
    logic                    sd_s;
    logic                    ws_edge_s;
    logic                    room_s;

    logic [NUM_BITS_DAC-1:0] shreg_r;
    logic [NUM_BITS_DAC-1:0] shreg_nxt_s;
    logic [NUM_BITS_DAC-1:0] commit_word_s;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_nxt_s;
    logic                    ws_last_r;
    logic                    primed_r;
    logic                    locked_r;

    logic                    commit_valid_r;
    logic                    commit_ch_r;
    logic [NUM_BITS_DAC-1:0] commit_word_r;
    logic                    short_word_r;

    logic [NUM_BITS_DAC-1:0] left_hold_r;
    logic                    have_left_r;
    logic                    push_r;
    logic [FRAME_W-1:0]      frame_r;
    logic [FRAME_W-1:0]      head_s;

    // Two-flop synchronisers plus the delayed s_clk used for rise detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= '0;
            ws_sync_r   <= '0;
            sd_sync_r   <= '0;
            sclk_d_r    <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], s_clk};
            ws_sync_r   <= {ws_sync_r[SYNC_STAGES-2:0], word_select};
            sd_sync_r   <= {sd_sync_r[SYNC_STAGES-2:0], serial_data};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
    assign ws_s   = ws_sync_r[SYNC_STAGES-1];
    assign sd_s   = sd_sync_r[SYNC_STAGES-1];

    // Next shift-register state: bits beyond NUM_BITS_DAC are dropped, and a committed word is left-aligned.
    always_comb begin
        room_s    = (count_r < FULL_CNT);
        ws_edge_s = primed_r && (ws_s != ws_last_r);
        if (room_s) begin
            shreg_nxt_s = {shreg_r[NUM_BITS_DAC-2:0], sd_s};
            count_nxt_s = count_r + CNT_W'(1);
        end else begin
            shreg_nxt_s = shreg_r;
            count_nxt_s = count_r;
        end
        commit_word_s = shreg_nxt_s << (FULL_CNT - count_nxt_s);
    end

    // Deserialiser; the first rise after reset only records word_select, since there is no earlier word to close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r        <= '0;
            count_r        <= '0;
            ws_last_r      <= 1'b0;
            primed_r       <= 1'b0;
            locked_r       <= 1'b0;
            commit_valid_r <= 1'b0;
            commit_ch_r    <= 1'b0;
            commit_word_r  <= '0;
            short_word_r   <= 1'b0;
        end else begin
            commit_valid_r <= 1'b0;
            short_word_r   <= 1'b0;
            if (rise_s) begin
                ws_last_r <= ws_s;
                primed_r  <= 1'b1;
                if (ws_edge_s) begin
                    shreg_r        <= '0;
                    count_r        <= '0;
                    commit_valid_r <= locked_r;
                    commit_ch_r    <= ws_last_r;
                    commit_word_r  <= commit_word_s;
                    short_word_r   <= locked_r && (count_nxt_s < FULL_CNT);
                    locked_r       <= 1'b1;
                end else begin
                    shreg_r <= shreg_nxt_s;
                    count_r <= count_nxt_s;
                end
            end
        end
    end

    // Pair a right word with the preceding left word; an unpaired right word is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_hold_r <= '0;
            have_left_r <= 1'b0;
            push_r      <= 1'b0;
            frame_r     <= '0;
        end else begin
            push_r <= 1'b0;
            if (commit_valid_r) begin
                if (commit_ch_r == CH_LEFT) begin
                    left_hold_r <= commit_word_r;
                    have_left_r <= 1'b1;
                end else begin
                    push_r      <= have_left_r;
                    frame_r     <= {left_hold_r, commit_word_r};
                    have_left_r <= 1'b0;
                end
            end
        end
    end

    i2s_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_r),
        .push_data (frame_r),
        .pop_ready (sample_ready),
        .head_data (head_s),
        .valid     (sample_valid),
        .overrun   (overrun)
    );

    assign sample_left  = head_s[FRAME_W-1 -: NUM_BITS_DAC];
    assign sample_right = head_s[NUM_BITS_DAC-1:0];
    assign short_word   = short_word_r;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Scoreboard bench for i2s_sample_rx: a bit-level stream builder feeds the serial lines,
// expected frames come from word-level alignment arithmetic, and a monitor checks every handshake.
module tb_i2s_sample_rx;

    localparam int N     = 24;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_clk;
    logic         word_select;
    logic         serial_data;
    logic         sample_ready;
    logic [N-1:0] sample_left;
    logic [N-1:0] sample_right;
    logic         sample_valid;
    logic         overrun;
    logic         short_word;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           ovr_cnt  = 0;
    int           sw_cnt   = 0;
    logic [N-1:0] exp_l_q[$];
    logic [N-1:0] exp_r_q[$];
    bit           q_sd[$];
    bit           q_ch[$];
    int           q_mark[$];
    int           cur_mark = 0;
    event         frame_end_ev;

    i2s_sample_rx #(.NUM_BITS_DAC(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_clk        (s_clk),
        .word_select  (word_select),
        .serial_data  (serial_data),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .short_word   (short_word)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Left-aligned N-bit value of a len-bit word: truncate long words, zero-pad short ones.
    function automatic logic [N-1:0] align(input logic [31:0] v, input int len);
        logic [63:0] w;
        w = 64'(v) & ((64'd1 << len) - 64'd1);
        if (len >= N) return N'(w >> (len - N));
        else return N'(w << (N - len));
    endfunction

    // Queue bits first..last-1 (MSB first) of a len-bit slot on channel ch.
    task automatic add_slot(input bit ch, input logic [31:0] v, input int len,
                            input int first, input int last, input int mark);
        for (int i = first; i < last; i++) begin
            q_ch.push_back(ch);
            q_sd.push_back(v[len-1-i]);
            q_mark.push_back((i == len - 1) ? mark : 0);
        end
    endtask

    task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int len,
                             input int mark, input bit score);
        add_slot(1'b0, l, len, 0, len, 0);
        add_slot(1'b1, r, len, 0, len, mark);
        if (score) begin
            exp_l_q.push_back(align(l, len));
            exp_r_q.push_back(align(r, len));
        end
    endtask

    // word_select leads the data by one bit, so it carries the channel of the next bit.
    task automatic send_stream();
        @(posedge clk);
        #7;
        for (int p = 0; p < q_sd.size(); p++) begin
            s_clk       = 1'b0;
            serial_data = q_sd[p];
            word_select = (p + 1 < q_sd.size()) ? q_ch[p+1] : q_ch[p];
            #40;
            s_clk    = 1'b1;
            cur_mark = q_mark[p];
            if (q_mark[p] != 0) -> frame_end_ev;
            #40;
        end
        s_clk = 1'b0;
        q_sd.delete();
        q_ch.delete();
        q_mark.delete();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        s_clk        = 1'b0;
        word_select  = 1'b0;
        serial_data  = 1'b0;
        sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_l_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check({"drain_", name}, 64'(exp_l_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1 check({"idle_valid_", name}, 64'(sample_valid), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_left"},    64'(sample_left),  64'd0);
        check({name, "_right"},   64'(sample_right), 64'd0);
        check({name, "_valid"},   64'(sample_valid), 64'd0);
        check({name, "_overrun"}, 64'(overrun),      64'd0);
        check({name, "_short"},   64'(short_word),   64'd0);
    endtask

    // Monitor: pulse counting and scoreboard comparison at every accepted frame.
    initial begin
        logic [N-1:0] el;
        logic [N-1:0] er;
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (short_word) sw_cnt++;
            if (!rst && sample_valid && sample_ready) begin
                if (exp_l_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got %h/%h expected none", sample_left, sample_right);
                end else begin
                    el = exp_l_q.pop_front();
                    er = exp_r_q.pop_front();
                    check("frame", 64'({sample_left, sample_right}), 64'({el, er}));
                end
            end
        end
    end

    // Edge-relative actions after a marked final right bit: 1 = latency check, 2 = single pop on the push cycle.
    initial begin
        forever begin
            @(frame_end_ev);
            if (cur_mark == 1) begin
                repeat (4) @(posedge clk);
                #1 check("latency_edge4_valid", 64'(sample_valid), 64'd0);
                @(posedge clk);
                #1 check("latency_edge5_valid", 64'(sample_valid), 64'd1);
            end else if (cur_mark == 2) begin
                repeat (4) @(posedge clk);
                #1 sample_ready = 1'b1;
                check("full_before_pushpop", 64'(sample_valid), 64'd1);
                @(posedge clk);
                #1 sample_ready = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          ovr0;
        int          sw0;
        logic [31:0] a_v;
        logic [31:0] b_v;

        // Reset state, sampled while reset is still held.
        rst          = 1'b1;
        s_clk        = 1'b0;
        word_select  = 1'b0;
        serial_data  = 1'b0;
        sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;

        // Nominal 24-bit frames, stream entered mid-right-word.
        sample_ready = 1'b1;
        ovr0 = ovr_cnt;
        sw0  = sw_cnt;
        add_slot(1'b1, $urandom, 24, 17, 24, 0);
        add_frame(32'h00A5A5A5, 32'h00123456, 24, 1, 1'b1);
        for (int i = 0; i < 2; i++) add_frame($urandom, $urandom, 24, 1, 1'b1);
        add_slot(1'b0, 32'h0, 24, 0, 4, 0);
        send_stream();
        wait_drain("nominal");
        check("nominal_short_count", 64'(sw_cnt - sw0), 64'd0);
        check("nominal_overrun_count", 64'(ovr_cnt - ovr0), 64'd0);

        // 16-bit words: zero-padded and flagged short.
        do_reset();
        sample_ready = 1'b1;
        ovr0 = ovr_cnt;
        sw0  = sw_cnt;
        add_slot(1'b1, $urandom, 16, 10, 16, 0);
        add_frame(32'h0000BEEF, $urandom, 16, 0, 1'b1);
        add_frame($urandom, $urandom, 16, 0, 1'b1);
        add_slot(1'b0, 32'h0, 16, 0, 4, 0);
        send_stream();
        wait_drain("short");
        check("short_pulse_count", 64'(sw_cnt - sw0), 64'd4);

        // 32-bit slots: the first 24 bits are kept.
        do_reset();
        sample_ready = 1'b1;
        sw0 = sw_cnt;
        add_slot(1'b1, $urandom, 32, 20, 32, 0);
        add_frame(32'hDEADBEEF, $urandom, 32, 0, 1'b1);
        add_frame($urandom, $urandom, 32, 0, 1'b1);
        add_slot(1'b0, 32'h0, 32, 0, 4, 0);
        send_stream();
        wait_drain("long");
        check("long_short_count", 64'(sw_cnt - sw0), 64'd0);

        // Partial left, then an unpaired right word: neither may be emitted.
        do_reset();
        sample_ready = 1'b1;
        sw0 = sw_cnt;
        add_slot(1'b0, $urandom, 24, 19, 24, 0);
        add_slot(1'b1, $urandom, 24, 0, 24, 0);
        add_frame($urandom, $urandom, 24, 0, 1'b1);
        add_frame($urandom, $urandom, 24, 0, 1'b1);
        add_slot(1'b0, 32'h0, 24, 0, 4, 0);
        send_stream();
        wait_drain("lock");
        check("lock_short_count", 64'(sw_cnt - sw0), 64'd0);

        // Backpressure: 6 frames into a 4-deep FIFO, then a push coinciding with one pop while full.
        do_reset();
        ovr0 = ovr_cnt;
        add_slot(1'b1, $urandom, 24, 12, 24, 0);
        for (int i = 0; i < 6; i++) add_frame($urandom, $urandom, 24, 0, (i < DEPTH));
        add_frame($urandom, $urandom, 24, 2, 1'b1);
        add_slot(1'b0, 32'h0, 24, 0, 4, 0);
        send_stream();
        repeat (10) @(posedge clk);
        #1 check("bp_overrun_count", 64'(ovr_cnt - ovr0), 64'd2);
        check("bp_still_valid", 64'(sample_valid), 64'd1);
        check("bp_retained", 64'(exp_l_q.size()), 64'd4);
        sample_ready = 1'b1;
        wait_drain("backpressure");
        check("bp_overrun_after_drain", 64'(ovr_cnt - ovr0), 64'd2);

        // Reset halfway through a right word with a frame waiting at the head.
        do_reset();
        a_v = $urandom;
        b_v = $urandom;
        add_slot(1'b1, $urandom, 24, 15, 24, 0);
        add_frame(a_v, b_v, 24, 0, 1'b0);
        add_slot(1'b0, $urandom, 24, 0, 24, 0);
        add_slot(1'b1, $urandom, 24, 0, 12, 0);
        send_stream();
        #1 check("rst_pre_valid", 64'(sample_valid), 64'd1);
        check("rst_pre_head", 64'({sample_left, sample_right}), 64'({align(a_v, 24), align(b_v, 24)}));
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sample_ready = 1'b1;
        add_slot(1'b1, $urandom, 24, 9, 24, 0);
        add_frame($urandom, $urandom, 24, 1, 1'b1);
        add_slot(1'b0, 32'h0, 24, 0, 4, 0);
        send_stream();
        wait_drain("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
